// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply sequencer: state encoding and index-width helper.
package mm_pkg;

  typedef logic [1:0] mm_state_t;

  localparam mm_state_t ST_IDLE  = 2'b00;
  localparam mm_state_t ST_MAC   = 2'b01;
  localparam mm_state_t ST_STORE = 2'b10;
  localparam mm_state_t ST_DONE  = 2'b11;

  // Index width for a counter spanning 0..n-1, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mm_idx_counter.sv
// Bounded index counter: counts 0..LIMIT-1, wraps to 0 on increment at terminal count.
module mm_idx_counter #(
  parameter int unsigned W     = 1,
  parameter int unsigned LIMIT = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_d;

  assign o_tc  = (r_cnt == LAST);
  assign o_cnt = r_cnt;

  always_comb begin
    w_cnt_d = r_cnt;
    if (i_clr) begin
      w_cnt_d = '0;
    end else if (i_inc) begin
      w_cnt_d = o_tc ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

endmodule

// File: rtl/mm_seq_ctrl.sv
// Sequencer for an ROWS x INNER by INNER x COLS matrix multiply: K MAC steps then one store per
// output entry, row-major. Define MM_STALL_EN to add the i_op_valid operand-stall input.
module mm_seq_ctrl
  import mm_pkg::*;
#(
  parameter int unsigned ROWS  = 2,
  parameter int unsigned COLS  = 2,
  parameter int unsigned INNER = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
`ifdef MM_STALL_EN
  input  logic                          i_op_valid,
`endif
  output logic                          o_busy,
  output logic [idx_width(ROWS)-1:0]    o_row_idx,
  output logic [idx_width(COLS)-1:0]    o_col_idx,
  output logic [idx_width(INNER)-1:0]   o_k_idx,
  output logic                          o_mac_en,
  output logic                          o_acc_clr,
  output logic                          o_wr_en,
  output logic                          o_done
);

  localparam int unsigned RW = idx_width(ROWS);
  localparam int unsigned CW = idx_width(COLS);
  localparam int unsigned KW = idx_width(INNER);

  mm_state_t r_state;
  mm_state_t w_state_d;

  logic          w_step;
  logic          w_idle;
  logic          w_k_inc;
  logic          w_col_inc;
  logic          w_row_inc;
  logic          w_k_tc;
  logic          w_col_tc;
  logic          w_row_tc;
  logic [KW-1:0] w_k;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;

`ifdef MM_STALL_EN
  assign w_step = i_op_valid;
`else
  assign w_step = 1'b1;
`endif

  assign w_idle    = (r_state == ST_IDLE);
  assign w_k_inc   = (r_state == ST_MAC) & w_step;
  assign w_col_inc = (r_state == ST_STORE);
  assign w_row_inc = (r_state == ST_STORE) & w_col_tc;

  // Counters wrap to 0 on their last increment, so indices already read 0 in DONE and IDLE.
  mm_idx_counter #(.W(KW), .LIMIT(INNER)) u_k_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_idle),
    .i_inc   (w_k_inc),
    .o_cnt   (w_k),
    .o_tc    (w_k_tc)
  );

  mm_idx_counter #(.W(CW), .LIMIT(COLS)) u_col_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_idle),
    .i_inc   (w_col_inc),
    .o_cnt   (w_col),
    .o_tc    (w_col_tc)
  );

  mm_idx_counter #(.W(RW), .LIMIT(ROWS)) u_row_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_idle),
    .i_inc   (w_row_inc),
    .o_cnt   (w_row),
    .o_tc    (w_row_tc)
  );

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_state_d = ST_MAC;
      ST_MAC:   if (w_step && w_k_tc) w_state_d = ST_STORE;
      ST_STORE: w_state_d = (w_col_tc && w_row_tc) ? ST_DONE : ST_MAC;
      ST_DONE:  w_state_d = ST_IDLE;
      default:  w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  assign o_busy    = ~w_idle;
  assign o_row_idx = w_row;
  assign o_col_idx = w_col;
  assign o_k_idx   = w_k;
  assign o_mac_en  = w_k_inc;
  // k holds at 0 through a stall, so the first step of an entry still clears.
  assign o_acc_clr = w_k_inc & (w_k == '0);
  assign o_wr_en   = (r_state == ST_STORE);
  assign o_done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Scoreboard bench for mm_seq_ctrl: three instances (2x2x2, 3x2x4, 1x1x1) share clock and reset.
module tb_mm_seq_ctrl;

  typedef struct {
    bit is_done;
    int row;
    int col;
    int cyc;
  } exp_t;

  exp_t q [3][$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   busy_cnt [3];
  int   clr_cnt  [3];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic st [3];
`ifdef MM_STALL_EN
  logic ov = 1'b1;
`endif

  logic busy [3];
  logic mac  [3];
  logic clr  [3];
  logic wr   [3];
  logic dn   [3];
  logic [1:0] row [3];
  logic [1:0] col [3];
  logic [1:0] kk  [3];

  logic       a_busy, a_mac, a_clr, a_wr, a_dn;
  logic [0:0] a_row, a_col, a_k;
  logic       b_busy, b_mac, b_clr, b_wr, b_dn;
  logic [1:0] b_row, b_k;
  logic [0:0] b_col;
  logic       c_busy, c_mac, c_clr, c_wr, c_dn;
  logic [0:0] c_row, c_col, c_k;

  mm_seq_ctrl #(.ROWS(2), .COLS(2), .INNER(2)) u_a (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (st[0]),
`ifdef MM_STALL_EN
    .i_op_valid (ov),
`endif
    .o_busy     (a_busy),
    .o_row_idx  (a_row),
    .o_col_idx  (a_col),
    .o_k_idx    (a_k),
    .o_mac_en   (a_mac),
    .o_acc_clr  (a_clr),
    .o_wr_en    (a_wr),
    .o_done     (a_dn)
  );

  mm_seq_ctrl #(.ROWS(3), .COLS(2), .INNER(4)) u_b (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (st[1]),
`ifdef MM_STALL_EN
    .i_op_valid (1'b1),
`endif
    .o_busy     (b_busy),
    .o_row_idx  (b_row),
    .o_col_idx  (b_col),
    .o_k_idx    (b_k),
    .o_mac_en   (b_mac),
    .o_acc_clr  (b_clr),
    .o_wr_en    (b_wr),
    .o_done     (b_dn)
  );

  mm_seq_ctrl #(.ROWS(1), .COLS(1), .INNER(1)) u_c (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (st[2]),
`ifdef MM_STALL_EN
    .i_op_valid (1'b1),
`endif
    .o_busy     (c_busy),
    .o_row_idx  (c_row),
    .o_col_idx  (c_col),
    .o_k_idx    (c_k),
    .o_mac_en   (c_mac),
    .o_acc_clr  (c_clr),
    .o_wr_en    (c_wr),
    .o_done     (c_dn)
  );

  assign busy[0] = a_busy;  assign mac[0] = a_mac;  assign clr[0] = a_clr;
  assign wr[0]   = a_wr;    assign dn[0]  = a_dn;
  assign row[0]  = {1'b0, a_row};  assign col[0] = {1'b0, a_col};  assign kk[0] = {1'b0, a_k};
  assign busy[1] = b_busy;  assign mac[1] = b_mac;  assign clr[1] = b_clr;
  assign wr[1]   = b_wr;    assign dn[1]  = b_dn;
  assign row[1]  = b_row;   assign col[1] = {1'b0, b_col};  assign kk[1] = b_k;
  assign busy[2] = c_busy;  assign mac[2] = c_mac;  assign clr[2] = c_clr;
  assign wr[2]   = c_wr;    assign dn[2]  = c_dn;
  assign row[2]  = {1'b0, c_row};  assign col[2] = {1'b0, c_col};  assign kk[2] = {1'b0, c_k};

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation for every wr_en / done the DUTs present.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (rst_n && (wr[d] || dn[d])) begin
        if (q[d].size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_event dut%0d: got wr=%0b done=%0b expected none (cyc %0d)",
                   d, wr[d], dn[d], cyc);
        end else begin
          e = q[d].pop_front();
          chk($sformatf("dut%0d_kind", d), int'(dn[d]), int'(e.is_done));
          chk($sformatf("dut%0d_cycle", d), cyc, e.cyc);
          if (!e.is_done) begin
            chk($sformatf("dut%0d_wr_row", d), int'(row[d]), e.row);
            chk($sformatf("dut%0d_wr_col", d), int'(col[d]), e.col);
          end
        end
      end
      if (rst_n && clr[d]) begin
        chk($sformatf("dut%0d_acc_clr_k0", d), int'(kk[d]), 0);
        chk($sformatf("dut%0d_acc_clr_mac", d), int'(mac[d]), 1);
        clr_cnt[d]++;
      end
      if (busy[d]) busy_cnt[d]++;
    end
  end

  task automatic push_ev(input int d, input bit is_done, input int r, input int c, input int at);
    exp_t e;
    e.is_done = is_done;
    e.row     = r;
    e.col     = c;
    e.cyc     = at;
    q[d].push_back(e);
  endtask

  // Unstalled run accepted on the edge that makes cyc == ce.
  task automatic push_run(input int d, input int nr, input int nc, input int nk, input int ce);
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < nc; c++)
        push_ev(d, 1'b0, r, c, ce + (r * nc + c) * (nk + 1) + nk);
    push_ev(d, 1'b1, 0, 0, ce + nr * nc * (nk + 1));
  endtask

  // Called at a negedge; returns at the negedge of cycle 0 of the run.
  task automatic start_pulse(input int d, output int ce);
    st[d] = 1'b1;
    ce = cyc + 1;
    @(negedge clk);
    st[d] = 1'b0;
  endtask

  initial begin
    int ce;
    int b0;
    int c0;
    for (int d = 0; d < 3; d++) begin
      st[d] = 1'b0;
      busy_cnt[d] = 0;
      clr_cnt[d] = 0;
    end

    // Reset state
    @(negedge clk);
    chk("rst_busy_a", int'(a_busy), 0);
    chk("rst_busy_b", int'(b_busy), 0);
    chk("rst_busy_c", int'(c_busy), 0);
    chk("rst_idx_b", int'({b_row, b_col, b_k}), 0);
    chk("rst_ctl_a", int'({a_mac, a_clr, a_wr, a_dn}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset asserted mid-MAC at cycle 4 aborts the run with no write or done
    start_pulse(0, ce);
    push_run(0, 2, 2, 2, ce);
    repeat (4) @(negedge clk);
    chk("pre_abort_busy", int'(a_busy), 1);
    rst_n = 1'b0;
    q[0].delete();
    @(negedge clk);
    chk("abort_busy", int'(a_busy), 0);
    chk("abort_ctl", int'({a_mac, a_clr, a_wr, a_dn}), 0);
    chk("abort_idx", int'({a_row, a_col, a_k}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full 2x2x2 run: writes at cycles 2,5,8,11, done at 12, busy 13 cycles
    b0 = busy_cnt[0];
    c0 = clr_cnt[0];
    start_pulse(0, ce);
    push_ev(0, 1'b0, 0, 0, ce + 2);
    push_ev(0, 1'b0, 0, 1, ce + 5);
    push_ev(0, 1'b0, 1, 0, ce + 8);
    push_ev(0, 1'b0, 1, 1, ce + 11);
    push_ev(0, 1'b1, 0, 0, ce + 12);
    repeat (13) @(negedge clk);
    #1;
    chk("a_busy_cycles", busy_cnt[0] - b0, 13);
    chk("a_acc_clr_count", clr_cnt[0] - c0, 4);
    chk("a_idle_after", int'(a_busy), 0);

    // 3x2x4: six writes, six clears, done at cycle 30
    @(negedge clk);
    b0 = busy_cnt[1];
    c0 = clr_cnt[1];
    start_pulse(1, ce);
    push_run(1, 3, 2, 4, ce);
    repeat (31) @(negedge clk);
    #1;
    chk("b_busy_cycles", busy_cnt[1] - b0, 31);
    chk("b_acc_clr_count", clr_cnt[1] - c0, 6);
    chk("b_idle_after", int'(b_busy), 0);

    // 1x1x1: mac+clear at 0, write at 1, done at 2, idle at 3
    @(negedge clk);
    start_pulse(2, ce);
    push_ev(2, 1'b0, 0, 0, ce + 1);
    push_ev(2, 1'b1, 0, 0, ce + 2);
    #1;
    chk("c_cyc0_mac", int'(c_mac), 1);
    chk("c_cyc0_clr", int'(c_clr), 1);
    repeat (3) @(negedge clk);
    #1;
    chk("c_cyc3_idle", int'(c_busy), 0);

`ifdef MM_STALL_EN
    // op_valid low for cycles 4-6 at k=1 of entry (0,1): everything slips 3 cycles
    @(negedge clk);
    start_pulse(0, ce);
    push_ev(0, 1'b0, 0, 0, ce + 2);
    push_ev(0, 1'b0, 0, 1, ce + 8);
    push_ev(0, 1'b0, 1, 0, ce + 11);
    push_ev(0, 1'b0, 1, 1, ce + 14);
    push_ev(0, 1'b1, 0, 0, ce + 15);
    repeat (4) @(negedge clk);
    ov = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_mac_en", int'(a_mac), 0);
      chk("stall_k", int'(a_k), 1);
      chk("stall_col", int'(a_col), 1);
      @(negedge clk);
    end
    ov = 1'b1;
    repeat (9) @(negedge clk);
    #1;
    chk("stall_idle_after", int'(a_busy), 0);
`endif

    // start held high through the run: second run begins after one IDLE cycle
    @(negedge clk);
    st[0] = 1'b1;
    ce = cyc + 1;
    push_run(0, 2, 2, 2, ce);
    push_run(0, 2, 2, 2, ce + 14);
    repeat (14) @(negedge clk);
    #1;
    chk("held_idle_gap", int'(a_busy), 0);
    @(negedge clk);
    #1;
    chk("held_rerun_busy", int'(a_busy), 1);
    chk("held_rerun_mac", int'(a_mac), 1);
    st[0] = 1'b0;
    repeat (13) @(negedge clk);
    #1;
    chk("held_idle_end", int'(a_busy), 0);

    for (int d = 0; d < 3; d++) chk($sformatf("dut%0d_pending", d), q[d].size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
